// File: rtl/branch_flag_unit_if.sv
// Branch/compare/redirect signal bundle shared between the pipeline and the
// branch flag unit. The unit takes the slave view; the pipeline side (or a
// bench) takes the master view.
interface branch_flag_unit_if #(
  parameter int PC_W = 8
);
  logic            cmp_issue;
  logic            cmp_valid;
  logic            cmp_zero;
  logic            br_valid;
  logic [1:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic            br_ready;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic            redirect_ready;
  logic            flush;
  logic            zero_flag;
  logic            err;

  modport master (
    output cmp_issue, cmp_valid, cmp_zero,
    output br_valid, br_cond, br_target,
    output redirect_ready,
    input  br_ready, redirect_valid, redirect_target, flush, zero_flag, err
  );

  modport slave (
    input  cmp_issue, cmp_valid, cmp_zero,
    input  br_valid, br_cond, br_target,
    input  redirect_ready,
    output br_ready, redirect_valid, redirect_target, flush, zero_flag, err
  );
endinterface

// File: rtl/branch_flag_unit.sv
// Branch flag unit: tracks the architectural zero flag and the number of
// compares still in flight, resolves conditional branches once no compare is
// outstanding, and issues a fetch redirect plus a one-cycle flush when taken.
module branch_flag_unit #(
  parameter int PC_W     = 8,
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_flag_unit_if.slave bus
);

  localparam int PEND_W = (MAX_PEND < 2) ? 1 : $clog2(MAX_PEND + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FLAG,
    REDIRECT
  } state_t;

  state_t            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              zero_flag_q, zero_flag_d;
  logic              err_q, err_d;
  logic [1:0]        cond_q, cond_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]   redirect_target_q, redirect_target_d;
  logic              flush_q, flush_d;

  logic              inc;
  logic              dec;
  logic              overflow;
  logic              underflow;
  logic              eff_zero;
  logic              resolve;
  logic [1:0]        res_cond;
  logic [PC_W-1:0]   res_target;

  // Taken rule: 00 always, 01 on zero, 10 on not-zero, 11 never.
  function automatic logic branch_taken(input logic [1:0] cond, input logic z);
    logic t;
    case (cond)
      2'b00:   t = 1'b1;
      2'b01:   t = z;
      2'b10:   t = ~z;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Pending-compare counter, zero flag and sticky error; runs in every state.
  always_comb begin
    inc         = bus.cmp_issue & ~bus.cmp_valid;
    dec         = bus.cmp_valid & ~bus.cmp_issue;
    overflow    = inc & (pend_q == PEND_MAX);
    underflow   = dec & (pend_q == '0);
    pend_d      = pend_q;
    if (inc && !overflow) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (dec && !underflow) begin
      pend_d = pend_q - PEND_W'(1);
    end
    zero_flag_d = bus.cmp_valid ? bus.cmp_zero : zero_flag_q;
    eff_zero    = bus.cmp_valid ? bus.cmp_zero : zero_flag_q;
    err_d       = err_q | overflow | underflow;
  end

  // Branch FSM: accept in IDLE, wait for outstanding compares, then redirect.
  always_comb begin
    state_d           = state_q;
    cond_d            = cond_q;
    target_d          = target_q;
    redirect_valid_d  = redirect_valid_q;
    redirect_target_d = redirect_target_q;
    flush_d           = 1'b0;
    resolve           = 1'b0;
    res_cond          = bus.br_cond;
    res_target        = bus.br_target;

    case (state_q)
      IDLE: begin
        if (bus.br_valid) begin
          if (bus.br_cond == 2'b00 || bus.br_cond == 2'b11 || pend_d == '0) begin
            resolve = 1'b1;
          end else begin
            cond_d   = bus.br_cond;
            target_d = bus.br_target;
            state_d  = WAIT_FLAG;
          end
        end
      end
      WAIT_FLAG: begin
        res_cond   = cond_q;
        res_target = target_q;
        if (pend_d == '0) begin
          resolve = 1'b1;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d          = IDLE;
          redirect_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (resolve) begin
      if (branch_taken(res_cond, eff_zero)) begin
        state_d           = REDIRECT;
        redirect_valid_d  = 1'b1;
        redirect_target_d = res_target;
        flush_d           = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // All state registers; reset abandons any branch in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      pend_q            <= '0;
      zero_flag_q       <= 1'b0;
      err_q             <= 1'b0;
      cond_q            <= 2'b00;
      target_q          <= '0;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
      flush_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      pend_q            <= pend_d;
      zero_flag_q       <= zero_flag_d;
      err_q             <= err_d;
      cond_q            <= cond_d;
      target_q          <= target_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_target_q <= redirect_target_d;
      flush_q           <= flush_d;
    end
  end

  assign bus.br_ready        = (state_q == IDLE);
  assign bus.redirect_valid  = redirect_valid_q;
  assign bus.redirect_target = redirect_target_q;
  assign bus.flush           = flush_q;
  assign bus.zero_flag       = zero_flag_q;
  assign bus.err             = err_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Bench for branch_flag_unit: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_branch_flag_unit;

  localparam int PC_W     = 8;
  localparam int MAX_PEND = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  branch_flag_unit_if #(.PC_W(PC_W)) bus ();

  branch_flag_unit #(.PC_W(PC_W), .MAX_PEND(MAX_PEND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Reference model state: compares in flight, flag, error, the branch that is
  // waiting for its flag (if any) and the redirect being offered (if any).
  int              m_pend;
  bit              m_flag;
  bit              m_err;
  bit              m_wait;
  bit [1:0]        m_cond;
  logic [PC_W-1:0] m_tgt;
  bit              m_redir;
  logic [PC_W-1:0] m_rtgt;
  bit              m_flush;

  function automatic bit isTaken(input bit [1:0] cond, input bit z);
    case (cond)
      2'b00:   return 1'b1;
      2'b01:   return z;
      2'b10:   return !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pend = 0; m_flag = 0; m_err = 0; m_wait = 0; m_cond = 0;
    m_tgt = '0; m_redir = 0; m_rtgt = '0; m_flush = 0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic modelStep(input bit issue, input bit valid, input bit zero, input bit bv,
                           input bit [1:0] cond, input logic [PC_W-1:0] tgt, input bit rready);
    int new_pend;
    bit ez;
    new_pend = m_pend + int'(issue) - int'(valid);
    if (new_pend > MAX_PEND) begin new_pend = MAX_PEND; m_err = 1; end
    if (new_pend < 0)        begin new_pend = 0;        m_err = 1; end
    ez = valid ? zero : m_flag;
    m_flush = 0;
    if (m_redir) begin
      if (rready) m_redir = 0;
    end else if (m_wait) begin
      if (new_pend == 0) begin
        m_wait = 0;
        if (isTaken(m_cond, ez)) begin m_redir = 1; m_rtgt = m_tgt; m_flush = 1; end
      end
    end else if (bv) begin
      if (cond == 2'b00 || cond == 2'b11 || new_pend == 0) begin
        if (isTaken(cond, ez)) begin m_redir = 1; m_rtgt = tgt; m_flush = 1; end
      end else begin
        m_wait = 1; m_cond = cond; m_tgt = tgt;
      end
    end
    m_pend = new_pend;
    if (valid) m_flag = zero;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/redirect_valid"},  bus.redirect_valid,  m_redir);
    checkOutput({tag, "/redirect_target"}, bus.redirect_target, m_rtgt);
    checkOutput({tag, "/flush"},           bus.flush,           m_flush);
    checkOutput({tag, "/zero_flag"},       bus.zero_flag,       m_flag);
    checkOutput({tag, "/err"},             bus.err,             m_err);
  endtask

  task automatic driveIdle();
    bus.cmp_issue = 0; bus.cmp_valid = 0; bus.cmp_zero = 0; bus.br_valid = 0;
    bus.br_cond = 2'b00; bus.br_target = '0; bus.redirect_ready = 0;
  endtask

  // Drive one cycle of inputs (called just after a rising edge), check
  // br_ready mid-cycle, then check registered outputs after the next edge.
  task automatic applyStimulus(input string tag, input bit issue, input bit valid, input bit zero,
                               input bit bv, input bit [1:0] cond, input logic [PC_W-1:0] tgt,
                               input bit rready);
    bus.cmp_issue = issue; bus.cmp_valid = valid; bus.cmp_zero = zero;
    bus.br_valid = bv; bus.br_cond = cond; bus.br_target = tgt; bus.redirect_ready = rready;
    @(negedge clk);
    checkOutput({tag, "/br_ready"}, bus.br_ready, (!m_wait && !m_redir));
    modelStep(issue, valid, zero, bv, cond, tgt, rready);
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must clear at once.
  task automatic doReset(input string tag);
    driveIdle();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll({tag, "/async"});
    checkOutput({tag, "/async/br_ready"}, bus.br_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    driveIdle();
    @(posedge clk);
    #1;
    doReset("por");

    // Unconditional branch right after reset.
    applyStimulus("always_taken", 0, 0, 0, 1, 2'b00, 8'h3C, 0);
    applyStimulus("always_ret",   0, 0, 0, 0, 2'b00, 8'h00, 1);

    // Same-cycle flag bypass with one compare in flight.
    applyStimulus("byp_issue", 1, 0, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("byp_br",    0, 1, 1, 1, 2'b01, 8'h55, 0);
    applyStimulus("byp_ret",   0, 0, 0, 0, 2'b00, 8'h00, 1);

    // Branch waits for two outstanding compares.
    applyStimulus("wait_iss1", 1, 0, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("wait_iss2", 1, 0, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("wait_br",   0, 0, 0, 1, 2'b10, 8'hA7, 0);
    applyStimulus("wait_cmp1", 0, 1, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("wait_cmp2", 0, 1, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("wait_hold", 0, 0, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("wait_ret",  0, 0, 0, 0, 2'b00, 8'h00, 1);

    // Not-taken conditional branch leaves the unit ready.
    applyStimulus("nt_br",   0, 0, 0, 1, 2'b01, 8'h77, 0);
    applyStimulus("nt_idle", 0, 0, 0, 0, 2'b00, 8'h00, 0);

    // Never-taken branch ignores outstanding compares.
    applyStimulus("never_iss", 1, 0, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("never_br",  0, 0, 0, 1, 2'b11, 8'h12, 0);
    applyStimulus("never_cmp", 0, 1, 1, 0, 2'b00, 8'h00, 0);

    // Counter overflow, then drain and underflow.
    for (int i = 0; i < 3; i++) applyStimulus("ovf_fill", 1, 0, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("ovf_hit", 1, 0, 0, 0, 2'b00, 8'h00, 0);
    for (int i = 0; i < 3; i++) applyStimulus("ovf_drain", 0, 1, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("unf_hit", 0, 1, 1, 0, 2'b00, 8'h00, 0);
    applyStimulus("unf_br",  0, 0, 0, 1, 2'b01, 8'h44, 0);
    applyStimulus("unf_ret", 0, 0, 0, 0, 2'b00, 8'h00, 1);

    // Reset while a redirect is being offered.
    doReset("pre_rd");
    applyStimulus("rd_flag", 0, 1, 1, 0, 2'b00, 8'h00, 0);
    applyStimulus("rd_br",   0, 0, 0, 1, 2'b00, 8'h99, 0);
    doReset("mid_rd");
    applyStimulus("rd_after", 0, 0, 0, 0, 2'b00, 8'h00, 0);

    // Reset while a branch waits for its flag.
    applyStimulus("wr_iss", 1, 0, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("wr_br",  0, 0, 0, 1, 2'b10, 8'h21, 0);
    doReset("mid_wait");
    applyStimulus("wr_cmp", 0, 1, 0, 0, 2'b00, 8'h00, 0);
    applyStimulus("wr_idle", 0, 0, 0, 0, 2'b00, 8'h00, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(59) == 0) begin
        doReset($sformatf("rnd_rst%0d", i));
      end
      applyStimulus($sformatf("rnd%0d", i),
                    ($urandom_range(9) < 3), ($urandom_range(9) < 3), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 2'($urandom_range(3)), PC_W'($urandom_range(255)),
                    ($urandom_range(3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
BRANCH_FLAG_UNIT -- requirements
Module: branch_flag_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, giving the branch target width in bits.
REQ-002 SHALL have parameter MAX_PEND, default 3, giving the maximum compares in flight (2-bit counter).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cmp_issue  in  1  a compare entered execute this cycle and its flag is not yet available.
REQ-006 cmp_valid  in  1  compare execute result valid this cycle.
REQ-007 cmp_zero  in  1  compare equality flag, qualified by cmp_valid.
REQ-008 br_valid  in  1  a branch is presented.
REQ-009 br_cond  in  2  branch condition: 00 always, 01 if zero, 10 if not zero, 11 never.
REQ-010 br_target  in  PC_W  branch target address.
REQ-011 br_ready  out  1  the unit accepts a branch this cycle.
REQ-012 redirect_valid  out  1  a fetch redirect is pending.
REQ-013 redirect_target  out  PC_W  redirect address, stable while redirect_valid=1.
REQ-014 redirect_ready  in  1  fetch accepts the redirect.
REQ-015 flush  out  1  one-cycle pulse that kills younger instructions.
REQ-016 zero_flag  out  1  architectural zero flag register.
REQ-017 err  out  1  sticky protocol error, either pending-count overflow or underflow.

Function
REQ-018 Flag: zero_flag SHALL load cmp_zero on every clk edge where cmp_valid=1, and hold otherwise.
REQ-019 Pending count: pend SHALL increment on cmp_issue only, decrement on cmp_valid only, and hold when both or neither are asserted. pend_next denotes this update.
REQ-020 Overflow: cmp_issue with pend=MAX_PEND and no cmp_valid SHALL leave pend unchanged and set err.
REQ-021 Underflow: cmp_valid with pend=0 and no cmp_issue SHALL leave pend at 0, set err, and still update zero_flag.
REQ-022 Effective flag: eff_zero SHALL be cmp_zero when cmp_valid=1 (same-cycle bypass), else zero_flag.
REQ-023 FSM states: IDLE, WAIT_FLAG, REDIRECT.
REQ-024 br_ready SHALL be 1 only in IDLE; a branch is accepted when br_valid and br_ready are both 1.
REQ-025 Accepted branch with cond 00 or 11 SHALL resolve in the acceptance cycle without consulting the flag.
REQ-026 Accepted branch with cond 01 or 10 and pend_next=0 SHALL resolve in the acceptance cycle using eff_zero.
REQ-027 Accepted branch with cond 01 or 10 and pend_next≠0 SHALL latch cond and target and go to WAIT_FLAG.
REQ-028 In WAIT_FLAG, resolution SHALL occur in the first cycle where pend_next=0, using eff_zero from that cycle.
REQ-029 Taken (00; 01 with eff_zero=1; 10 with eff_zero=0): next state SHALL be REDIRECT, with redirect_target loaded from the latched target.
REQ-030 On a taken branch, flush SHALL be 1 in exactly the first REDIRECT cycle.
REQ-031 Not taken: next state SHALL be IDLE, with no flush and no redirect.
REQ-032 REDIRECT SHALL hold redirect_valid=1 and a constant target until redirect_ready=1, then return to IDLE on the next edge.
REQ-033 Latency: taken branch accepted at cycle N resolved immediately → redirect_valid=1 and flush=1 at N+1.
REQ-034 A branch accepted in the same cycle that redirect_valid falls SHALL not occur; br_ready=0 in REDIRECT.
REQ-035 Compare counting and flag updates SHALL continue in every state.

Reset
REQ-036 While rst_n=0, asynchronously: state=IDLE, pend=0, zero_flag=0, err=0, redirect_valid=0, redirect_target=0, flush=0.
REQ-037 br_ready SHALL be 1 in the first cycle after reset release.
REQ-038 Reset asserted mid-WAIT_FLAG or mid-REDIRECT SHALL abandon the branch, with no redirect issued after release.

Verification
REQ-039 Reset, then br_valid, cond=00, target=0x3C → redirect_valid=1, flush=1, and target=0x3C next cycle; with redirect_ready=1, IDLE the cycle after.
REQ-040 cmp_valid, cmp_zero=1 in the same cycle as br cond=01 with pend=1 → bypass used, taken, redirect at N+1.
REQ-041 Two cmp_issue, then br cond=10 → WAIT_FLAG; cmp_valid zero=0 twice → resolves taken on the second, redirect next cycle.
REQ-042 cond=01 with zero_flag=0 and pend=0 → not taken, flush=0, br_ready stays 1.
REQ-043 pend=3 with cmp_issue → err=1 and pend=3; cmp_valid with pend=0 → err remains 1 and zero_flag updates.
REQ-044 rst_n pulled low in REDIRECT with redirect_ready=0 → redirect_valid=0 immediately; after release, IDLE with zero_flag=0.
